uart_fifo_trx: RTL and testbench
================================

UART_FIFO_TRX -- requirements
Module: uart_fifo_trx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2604, meaning clk cycles per bit, legal range 8..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, meaning 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter TX_DEPTH, default 4, meaning TX FIFO entries, power of 2, minimum 2.
REQ-005 SHALL have parameter RX_DEPTH, default 4, meaning RX FIFO entries, power of 2, minimum 2.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port tx_data, input, DATA_BITS bits: word to push into the TX FIFO.
REQ-009 SHALL have port tx_wr, input, 1 bit: push tx_data into the TX FIFO.
REQ-010 SHALL have port tx_full, output, 1 bit: TX FIFO full.
REQ-011 SHALL have port tx_done, output, 1 bit: one-cycle pulse at the end of each transmitted stop bit.
REQ-012 SHALL have port tx_idle, output, 1 bit: TX FIFO empty and TX FSM in IDLE.
REQ-013 SHALL have port TX, output, 1 bit: serial out line, idle high.
REQ-014 SHALL have port RX, input, 1 bit: asynchronous serial in line.
REQ-015 SHALL have port rx_data, output, DATA_BITS bits: head of the RX FIFO (show-ahead).
REQ-016 SHALL have port rx_rd, input, 1 bit: pop the RX FIFO head.
REQ-017 SHALL have port rx_rdy, output, 1 bit: RX FIFO non-empty.
REQ-018 SHALL have port rx_overrun, output, 1 bit: sticky flag, frame lost because the RX FIFO was full.
REQ-019 SHALL have port parity_err, output, 1 bit: sticky flag, parity mismatch.
REQ-020 SHALL have port frame_err, output, 1 bit: sticky flag, stop bit sampled low.
REQ-021 SHALL have port clr_err, input, 1 bit: clears all three sticky flags.

Function
REQ-022 SHALL frame as: start bit (0), DATA_BITS data bits LSB first, a parity bit only when PARITY!=0, one stop bit (1); each bit lasts exactly CLK_DIV clk cycles.
REQ-023 TX FIFO SHALL accept tx_wr when !tx_full; tx_wr while tx_full SHALL be dropped, even if a pop occurs in the same cycle.
REQ-024 TX FSM SHALL use states IDLE, START, DATA, PAR, STOP; PAR SHALL be skipped when PARITY==0.
REQ-025 In IDLE with the TX FIFO non-empty, the FSM SHALL pop the head and drive TX low starting on the next cycle.
REQ-026 On STOP completion, tx_done SHALL pulse; the FSM SHALL go directly to START if the FIFO is non-empty (back-to-back frames, no idle gap), else to IDLE.
REQ-027 A word pushed in the same cycle that the FIFO goes empty-to-non-empty SHALL be sent with 1-cycle latency from push to TX falling.
REQ-028 RX SHALL be double-flop synchronised, with both flops reset to 1; all RX decisions SHALL use the synchronised value.
REQ-029 RX FSM SHALL use states IDLE, START, DATA, PAR, STOP; a synchronised falling edge in IDLE enters START.
REQ-030 START SHALL sample at CLK_DIV/2 cycles; if the sample is high the FSM SHALL return to IDLE (false start, no flag).
REQ-031 Each subsequent bit SHALL be sampled CLK_DIV cycles after the previous sample.
REQ-032 A stop bit sampled low SHALL set frame_err and discard the word; the FSM SHALL then wait in IDLE for the line to be high before arming.
REQ-033 A parity mismatch SHALL set parity_err and the word SHALL still be written.
REQ-034 At the stop-bit sample, a valid word SHALL be written to the RX FIFO; rx_rdy SHALL rise on the next cycle.
REQ-035 A write while the RX FIFO is full and rx_rd is low SHALL be dropped and set rx_overrun.
REQ-036 A write and an rx_rd in the same cycle while the RX FIFO is full SHALL both succeed with no overrun.
REQ-037 rx_rd while the RX FIFO is empty SHALL be ignored.
REQ-038 clr_err SHALL clear the sticky flags; a flag-set event in the same cycle as clr_err SHALL win.
REQ-039 FIFO pointers SHALL wrap modulo depth; full/empty SHALL be derived from an extra pointer bit.

Reset
REQ-040 On rst, both FSMs SHALL go to IDLE, both FIFOs SHALL empty, and all baud and bit counters SHALL clear.
REQ-041 Reset values: TX=1, tx_done=0, tx_full=0, tx_idle=1, rx_rdy=0, rx_data=0, rx_overrun=0, parity_err=0, frame_err=0.
REQ-042 rst mid-frame SHALL abort the frame immediately with TX=1 on the next cycle and no tx_done; a partially received word SHALL be lost.

Verification (CLK_DIV=16, DATA_BITS=8 unless stated)
REQ-043 PARITY=0, push 0xA5, TX looped to RX -> TX low 1 cycle after push, frame lasts 160 cycles, rx_rdy rises, rx_data=0xA5, tx_done pulses once.
REQ-044 Push 0x01, 0x02, 0x03, 0x04, 0x05 with no pops, TX_DEPTH=4 -> tx_full asserts after the fourth push minus the first pop; the fifth push is accepted only if not full; frames are sent back-to-back with no gap.
REQ-045 RX_DEPTH=4, receive 5 frames without rx_rd -> first 4 stored in order, rx_overrun=1; then pop+write in the same cycle -> no overrun.
REQ-046 PARITY=1, inject 0x07 with parity bit 0 -> word 0x07 stored, parity_err=1; clr_err -> 0.
REQ-047 Inject stop bit low -> frame_err=1 and nothing written; a 4-cycle low glitch -> no word and no flags.
REQ-048 Assert rst at bit 3 of a TX frame -> TX=1 the next cycle, tx_idle=1, FIFO empty, tx_done stays 0.

Source files
------------

// File: rtl/uart_fifo_trx.sv
// UART transceiver with show-ahead TX and RX FIFOs, optional parity and sticky error flags.
// Frame: start(0), DATA_BITS LSB first, optional parity, one stop(1); each bit lasts CLK_DIV clocks.
`timescale 1ns/1ps
module uart_fifo_trx #(
  parameter int CLK_DIV   = 2604,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int TX_DEPTH  = 4,
  parameter int RX_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_wr,
  output logic                 tx_full,
  output logic                 tx_done,
  output logic                 tx_idle,
  output logic                 TX,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_rd,
  output logic                 rx_rdy,
  output logic                 rx_overrun,
  output logic                 parity_err,
  output logic                 frame_err,
  input  logic                 clr_err
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);
  localparam logic [3:0]  BIT_LAST  = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    par_bit = (PARITY == 2) ? ~(^d) : (^d);
  endfunction

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
  logic [TAW:0] tx_wptr, tx_rptr;
  logic tx_empty, tx_push, tx_pop;

  assign tx_empty = (tx_wptr == tx_rptr);
  assign tx_full  = (tx_wptr[TAW] != tx_rptr[TAW]) && (tx_wptr[TAW-1:0] == tx_rptr[TAW-1:0]);
  assign tx_push  = tx_wr && !tx_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wptr[TAW-1:0]] <= tx_data;
        tx_wptr <= tx_wptr + {{TAW{1'b0}}, 1'b1};
      end
      if (tx_pop) tx_rptr <= tx_rptr + {{TAW{1'b0}}, 1'b1};
    end
  end

  // ---------------- TX FSM ----------------
  state_t tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [3:0]  tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
  logic tx_par, tx_par_n, tx_line_n, tx_done_n, tx_tick;

  assign tx_tick = (tx_cnt == DIV_LAST);
  assign tx_idle = tx_empty && (tx_state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      TX       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      tx_par   <= tx_par_n;
      TX       <= tx_line_n;
      tx_done  <= tx_done_n;
    end
  end

  // The shift register is loaded on pop; each bit is presented from bit 0 and shifted out.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_tick ? 16'd0 : tx_cnt + 16'd1;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_par_n   = tx_par;
    tx_line_n  = TX;
    tx_done_n  = 1'b0;
    tx_pop     = 1'b0;
    case (tx_state)
      IDLE: begin
        tx_cnt_n = 16'd0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_sh_n    = tx_mem[tx_rptr[TAW-1:0]];
          tx_par_n   = par_bit(tx_mem[tx_rptr[TAW-1:0]]);
          tx_state_n = START;
          tx_line_n  = 1'b0;
        end else begin
          tx_line_n  = 1'b1;
        end
      end
      START: begin
        if (tx_tick) begin
          tx_state_n = DATA;
          tx_bit_n   = 4'd0;
          tx_line_n  = tx_sh[0];
          tx_sh_n    = tx_sh >> 1;
        end else begin
          tx_line_n  = 1'b0;
        end
      end
      DATA: begin
        if (tx_tick && (tx_bit == BIT_LAST)) begin
          tx_state_n = (PARITY != 0) ? PAR : STOP;
          tx_line_n  = (PARITY != 0) ? tx_par : 1'b1;
        end else if (tx_tick) begin
          tx_bit_n   = tx_bit + 4'd1;
          tx_line_n  = tx_sh[0];
          tx_sh_n    = tx_sh >> 1;
        end else begin
          tx_bit_n   = tx_bit;
        end
      end
      PAR: begin
        if (tx_tick) begin
          tx_state_n = STOP;
          tx_line_n  = 1'b1;
        end else begin
          tx_line_n  = tx_par;
        end
      end
      STOP: begin
        if (tx_tick && !tx_empty) begin
          tx_done_n  = 1'b1;
          tx_pop     = 1'b1;
          tx_sh_n    = tx_mem[tx_rptr[TAW-1:0]];
          tx_par_n   = par_bit(tx_mem[tx_rptr[TAW-1:0]]);
          tx_state_n = START;
          tx_line_n  = 1'b0;
        end else if (tx_tick) begin
          tx_done_n  = 1'b1;
          tx_state_n = IDLE;
          tx_line_n  = 1'b1;
        end else begin
          tx_line_n  = 1'b1;
        end
      end
      default: begin
        tx_state_n = IDLE;
        tx_line_n  = 1'b1;
      end
    endcase
  end

  // ---------------- RX synchroniser and FSM ----------------
  logic rx_s1, rx_s2, rx_prev;
  state_t rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n;
  logic [3:0]  rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
  logic rx_wr, par_set, frm_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_s1    <= RX;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
    end
  end

  // Arming needs a high-to-low edge, so a line held low after a bad stop bit is ignored.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 16'd1;
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    rx_wr      = 1'b0;
    par_set    = 1'b0;
    frm_set    = 1'b0;
    case (rx_state)
      IDLE: begin
        rx_cnt_n = 16'd0;
        if (rx_prev && !rx_s2) rx_state_n = START;
        else rx_state_n = IDLE;
      end
      START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = 16'd0;
          rx_bit_n   = 4'd0;
          rx_state_n = rx_s2 ? IDLE : DATA;
        end else begin
          rx_state_n = START;
        end
      end
      DATA: begin
        if (rx_cnt == DIV_LAST) begin
          rx_cnt_n = 16'd0;
          rx_sh_n  = {rx_s2, rx_sh[DATA_BITS-1:1]};
          rx_bit_n = rx_bit + 4'd1;
          if (rx_bit == BIT_LAST) rx_state_n = (PARITY != 0) ? PAR : STOP;
          else rx_state_n = DATA;
        end else begin
          rx_state_n = DATA;
        end
      end
      PAR: begin
        if (rx_cnt == DIV_LAST) begin
          rx_cnt_n   = 16'd0;
          par_set    = (rx_s2 != par_bit(rx_sh));
          rx_state_n = STOP;
        end else begin
          rx_state_n = PAR;
        end
      end
      STOP: begin
        if (rx_cnt == DIV_LAST) begin
          rx_cnt_n   = 16'd0;
          rx_wr      = rx_s2;
          frm_set    = !rx_s2;
          rx_state_n = IDLE;
        end else begin
          rx_state_n = STOP;
        end
      end
      default: rx_state_n = IDLE;
    endcase
  end

  // ---------------- RX FIFO and sticky flags ----------------
  logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
  logic [RAW:0] rx_wptr, rx_rptr;
  logic rx_empty, rx_full, rx_push, rx_pop, ovr_set;

  assign rx_empty = (rx_wptr == rx_rptr);
  assign rx_full  = (rx_wptr[RAW] != rx_rptr[RAW]) && (rx_wptr[RAW-1:0] == rx_rptr[RAW-1:0]);
  assign rx_pop   = rx_rd && !rx_empty;
  assign rx_push  = rx_wr && (!rx_full || rx_rd);
  assign ovr_set  = rx_wr && rx_full && !rx_rd;
  assign rx_rdy   = !rx_empty;
  assign rx_data  = rx_empty ? '0 : rx_mem[rx_rptr[RAW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wptr    <= '0;
      rx_rptr    <= '0;
      rx_overrun <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wptr[RAW-1:0]] <= rx_sh;
        rx_wptr <= rx_wptr + {{RAW{1'b0}}, 1'b1};
      end
      if (rx_pop) rx_rptr <= rx_rptr + {{RAW{1'b0}}, 1'b1};
      if (ovr_set) rx_overrun <= 1'b1;
      else if (clr_err) rx_overrun <= 1'b0;
      if (par_set) parity_err <= 1'b1;
      else if (clr_err) parity_err <= 1'b0;
      if (frm_set) frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_fifo_trx.sv
// Directed bench: dut0 (no parity, TX loopback selectable) and dut1 (even parity), CLK_DIV=16.
`timescale 1ns/1ps
module tb_uart_fifo_trx;
  localparam int CD = 16;

  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] tx_data0 = 8'h00, tx_data1 = 8'h00;
  logic tx_wr0 = 1'b0, tx_wr1 = 1'b0;
  logic tx_full0, tx_done0, tx_idle0, tx0, tx_full1, tx_done1, tx_idle1, tx1;
  logic [7:0] rx_data0, rx_data1;
  logic rx_rdy0, ov0, pe0, fe0, rx_rdy1, ov1, pe1, fe1;
  logic loop = 1'b0, drv0 = 1'b1, drv1 = 1'b1;
  logic rx_rd0 = 1'b0, rx_rd1 = 1'b0, clr0 = 1'b0, clr1 = 1'b0;
  logic rx_line0;
  int checks = 0, errors = 0, done_cnt0 = 0;

  assign rx_line0 = loop ? tx0 : drv0;

  uart_fifo_trx #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(0), .TX_DEPTH(4), .RX_DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data0), .tx_wr(tx_wr0), .tx_full(tx_full0),
    .tx_done(tx_done0), .tx_idle(tx_idle0), .TX(tx0), .RX(rx_line0), .rx_data(rx_data0),
    .rx_rd(rx_rd0), .rx_rdy(rx_rdy0), .rx_overrun(ov0), .parity_err(pe0), .frame_err(fe0),
    .clr_err(clr0));

  uart_fifo_trx #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(1), .TX_DEPTH(4), .RX_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_wr(tx_wr1), .tx_full(tx_full1),
    .tx_done(tx_done1), .tx_idle(tx_idle1), .TX(tx1), .RX(drv1), .rx_data(rx_data1),
    .rx_rd(rx_rd1), .rx_rdy(rx_rdy1), .rx_overrun(ov1), .parity_err(pe1), .frame_err(fe1),
    .clr_err(clr1));

  always #5 clk = ~clk;

  always @(negedge clk) if (tx_done0) done_cnt0 <= done_cnt0 + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit         sel;
    logic [7:0] d;
    logic       pb;
    logic       stopb;
    logic       rdy;
    logic [7:0] exp_d;
    logic       pe;
    logic       fe;
  } vec_t;
  vec_t vecs [7];

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%b exp=%b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one frame on the selected RX line; rx_rd / clr_err pulse at the given bit-cycle index.
  task automatic send(input bit sel, input logic [7:0] d, input bit has_par, input logic pb,
                      input logic stopb, input int rd_at, input int clr_at);
    logic [10:0] bits;
    int n;
    logic b;
    bits = has_par ? {stopb, pb, d, 1'b0} : {1'b1, stopb, d, 1'b0};
    n = has_par ? 11 * CD : 10 * CD;
    for (int i = 0; i < n; i++) begin
      b = bits[i / CD];
      if (sel) begin drv1 = b; rx_rd1 = (i == rd_at); clr1 = (i == clr_at); end
      else begin drv0 = b; rx_rd0 = (i == rd_at); clr0 = (i == clr_at); end
      cyc();
    end
    drv0 = 1'b1; drv1 = 1'b1; rx_rd0 = 1'b0; rx_rd1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
    repeat (8) cyc();
  endtask

  task automatic pop(input bit sel);
    if (sel) rx_rd1 = 1'b1; else rx_rd0 = 1'b1;
    cyc();
    rx_rd0 = 1'b0; rx_rd1 = 1'b0;
  endtask

  task automatic clear(input bit sel);
    if (sel) clr1 = 1'b1; else clr0 = 1'b1;
    cyc();
    clr0 = 1'b0; clr1 = 1'b0;
  endtask

  initial begin
    int k, d0, lows;
    int dts[$];
    logic [7:0] got[$];
    logic [7:0] exp_ovr[4];

    vecs[0] = '{1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};
    exp_ovr = '{8'h22, 8'h33, 8'h44, 8'h66};

    // Reset values
    repeat (3) cyc();
    chk1("rst_tx", tx0, 1'b1);
    chk1("rst_tx_done", tx_done0, 1'b0);
    chk1("rst_tx_full", tx_full0, 1'b0);
    chk1("rst_tx_idle", tx_idle0, 1'b1);
    chk1("rst_rx_rdy", rx_rdy0, 1'b0);
    chk8("rst_rx_data", rx_data0, 8'h00);
    chk1("rst_overrun", ov0, 1'b0);
    chk1("rst_parity_err", pe0, 1'b0);
    chk1("rst_frame_err", fe0, 1'b0);
    rst = 1'b0;
    repeat (4) cyc();

    // Loopback of a single word
    loop = 1'b1;
    d0 = done_cnt0;
    tx_data0 = 8'hA5; tx_wr0 = 1'b1;
    cyc();
    tx_wr0 = 1'b0;
    chk1("tx_before_fall", tx0, 1'b1);
    cyc();
    chk1("tx_fall_latency", tx0, 1'b0);
    k = 0;
    while (!tx_done0 && k < 400) begin cyc(); k++; end
    chki("frame_len", k, 160);
    chk1("loop_rx_rdy", rx_rdy0, 1'b1);
    chk8("loop_rx_data", rx_data0, 8'hA5);
    cyc();
    chk1("tx_done_pulse", tx_done0, 1'b0);
    pop(1'b0);
    chk1("loop_rx_empty", rx_rdy0, 1'b0);
    repeat (20) cyc();
    chki("loop_done_count", done_cnt0 - d0, 1);
    chk1("loop_tx_idle", tx_idle0, 1'b1);

    // Six back-to-back pushes: fifth accepted, sixth dropped while full
    for (int i = 1; i <= 6; i++) begin
      tx_data0 = 8'(i); tx_wr0 = 1'b1;
      cyc();
      if (i == 4) chk1("full_after4", tx_full0, 1'b0);
      if (i == 5) chk1("full_after5", tx_full0, 1'b1);
    end
    tx_wr0 = 1'b0;
    chk1("full_after6", tx_full0, 1'b1);
    for (int c = 0; c < 1300; c++) begin
      if (tx_done0) dts.push_back(c);
      if (rx_rdy0 && !rx_rd0) begin got.push_back(rx_data0); rx_rd0 = 1'b1; end
      else rx_rd0 = 1'b0;
      cyc();
    end
    rx_rd0 = 1'b0;
    chki("b2b_rx_count", got.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < got.size()) chk8("b2b_rx_word", got[i], 8'(i + 1));
    chki("b2b_done_count", dts.size(), 5);
    for (int i = 1; i < 5; i++)
      if (i < dts.size()) chki("b2b_gap", dts[i] - dts[i-1], 160);
    loop = 1'b0;
    repeat (4) cyc();

    // RX overrun, then simultaneous write and read while full
    for (int i = 1; i <= 5; i++) send(1'b0, 8'(i * 17), 1'b0, 1'b0, 1'b1, -1, -1);
    chk1("ovr_set", ov0, 1'b1);
    chk8("ovr_head", rx_data0, 8'h11);
    clear(1'b0);
    chk1("ovr_clr", ov0, 1'b0);
    send(1'b0, 8'h66, 1'b0, 1'b0, 1'b1, 154, -1);
    chk1("ovr_simul_none", ov0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk1("ovr_rdy", rx_rdy0, 1'b1);
      chk8("ovr_word", rx_data0, exp_ovr[i]);
      pop(1'b0);
    end
    chk1("ovr_empty", rx_rdy0, 1'b0);
    pop(1'b0);
    chk1("rd_empty_ignored", rx_rdy0, 1'b0);

    // Table of injected frames
    foreach (vecs[i]) begin
      send(vecs[i].sel, vecs[i].d, vecs[i].sel, vecs[i].pb, vecs[i].stopb, -1, -1);
      chk1("vec_rdy", vecs[i].sel ? rx_rdy1 : rx_rdy0, vecs[i].rdy);
      if (vecs[i].rdy) chk8("vec_data", vecs[i].sel ? rx_data1 : rx_data0, vecs[i].exp_d);
      chk1("vec_parity_err", vecs[i].sel ? pe1 : pe0, vecs[i].pe);
      chk1("vec_frame_err", vecs[i].sel ? fe1 : fe0, vecs[i].fe);
      if (vecs[i].rdy) pop(vecs[i].sel);
      clear(vecs[i].sel);
      chk1("vec_pe_cleared", vecs[i].sel ? pe1 : pe0, 1'b0);
      chk1("vec_fe_cleared", vecs[i].sel ? fe1 : fe0, 1'b0);
    end

    // Flag set in the same cycle as clr_err wins
    send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, -1, 154);
    chk1("set_beats_clr_pe", pe1, 1'b1);
    pop(1'b1);
    clear(1'b1);
    send(1'b0, 8'h81, 1'b0, 1'b0, 1'b0, -1, 154);
    chk1("set_beats_clr_fe", fe0, 1'b1);
    clear(1'b0);

    // Short low glitch is a false start
    drv0 = 1'b0;
    repeat (4) cyc();
    drv0 = 1'b1;
    repeat (40) cyc();
    chk1("glitch_rdy", rx_rdy0, 1'b0);
    chk1("glitch_fe", fe0, 1'b0);
    chk1("glitch_pe", pe0, 1'b0);

    // Reset in the middle of data bit 3
    tx_data0 = 8'hF0; tx_wr0 = 1'b1;
    cyc();
    tx_data0 = 8'h0F;
    cyc();
    tx_wr0 = 1'b0;
    k = 0;
    while (tx0 && k < 50) begin cyc(); k++; end
    chk1("rst_test_fall", tx0, 1'b0);
    repeat (CD * 4 + 5) cyc();
    chk1("busy_before_rst", tx_idle0, 1'b0);
    d0 = done_cnt0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk1("mid_rst_tx", tx0, 1'b1);
    chk1("mid_rst_idle", tx_idle0, 1'b1);
    chk1("mid_rst_full", tx_full0, 1'b0);
    chk1("mid_rst_done", tx_done0, 1'b0);
    lows = 0;
    repeat (200) begin
      cyc();
      if (!tx0) lows++;
    end
    chki("mid_rst_no_frame", lows, 0);
    chki("mid_rst_no_done", done_cnt0 - d0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
